// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO register pair with multiply/accumulate and a restoring iterative divider
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic [2*WIDTH-1:0] hilo_o,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, PRE, ITER, POST} state_t;
  state_t             state;
  logic [WIDTH-1:0]   hi, lo, rem, quo, dvs, dvd_raw;
  logic [CW-1:0]      cnt;
  logic               qneg, rneg, divz;
  logic               accept, sgn, is_mul, is_acc, is_sub, is_div, is_mthi, is_mtlo;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic [WIDTH:0]     sh, diff;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_s, rem_s;
  assign busy    = state != IDLE;
  assign accept  = ~busy & op_valid & ~cancel;
  assign sgn     = ~op[0];
  assign is_mul  = op[3:1] == 3'b000;
  assign is_div  = op[3:1] == 3'b001;
  assign is_acc  = op[3:1] == 3'b010;
  assign is_sub  = op[3:1] == 3'b011;
  assign is_mthi = op == 4'd8;
  assign is_mtlo = op == 4'd9;
  // Sign-extending to 2*WIDTH makes one multiplier serve both signed and unsigned products
  assign ext_a  = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign ext_b  = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign prod   = ext_a * ext_b;
  assign acc    = is_mul ? prod : is_acc ? {hi, lo} + prod : {hi, lo} - prod;
  assign abs_a  = sgn & a[WIDTH-1] ? -a : a;
  assign abs_b  = sgn & b[WIDTH-1] ? -b : b;
  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract
  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = sh - {1'b0, dvs};
  assign quo_s  = qneg ? -quo : quo;
  assign rem_s  = rneg ? -rem : rem;
  // MT data is forwarded in its issue cycle so a dependent read sees it without a bubble
  assign hilo_o = {accept & is_mthi ? a : hi, accept & is_mtlo ? a : lo};
  // Operation issue, divide sequencing and HI/LO update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      cnt     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      divz    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel && busy) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (accept) begin
            if (is_mthi) hi <= a;
            if (is_mtlo) lo <= a;
            if (is_mul || is_acc || is_sub) begin
              {hi, lo} <= acc;
              done     <= 1'b1;
            end
            if (is_div) begin
              state   <= PRE;
              dvd_raw <= a;
              quo     <= abs_a;
              dvs     <= abs_b;
              qneg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg    <= sgn & a[WIDTH-1];
              divz    <= b == '0;
            end
          end
          PRE: begin
            rem   <= '0;
            cnt   <= CW'(WIDTH - 1);
            state <= ITER;
          end
          ITER: begin
            rem   <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt   <= cnt - CW'(1);
            state <= cnt == '0 ? POST : ITER;
          end
          POST: begin
            hi    <= divz ? dvd_raw : rem_s;
            lo    <= divz ? '1 : quo_s;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed vector table, randomized model check and divide corner sequences for hilo_mdu
module tb_hilo_mdu;
  localparam int W = 32;
  logic          clk = 1'b0;
  logic          rst, op_valid, cancel, busy, done;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic [2*W-1:0] hilo_o;
  logic [63:0]   mdl;
  int            n_chk = 0, n_fail = 0;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .cancel(cancel), .hilo_o(hilo_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO value
  function automatic logic [63:0] ref_op(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, q, r;
    bit s;
    s  = o inside {4'd0, 4'd2, 4'd4, 4'd6};
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    case (o)
      4'd0, 4'd1: return 64'(sx * sy);
      4'd4, 4'd5: return cur + 64'(sx * sy);
      4'd6, 4'd7: return cur - 64'(sx * sy);
      4'd2, 4'd3: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4'd8: return {x, cur[31:0]};
      4'd9: return {cur[63:32], x};
      default: return cur;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] o);
    return o inside {4'd2, 4'd3} ? W + 2 : o <= 4'd7 ? 0 : -1;
  endfunction

  // Issue one op, then wait (bounded) for done; lat = edges after accept until done, -1 if none
  task automatic run(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     output int lat, output logic [63:0] fwd);
    int n;
    @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = y;
    #1 fwd = hilo_o;
    @(posedge clk);
    #1 op_valid = 1'b0;
    if (o <= 4'd7) begin
      n = 0;
      while (!done && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      lat = done ? n : 999;
    end else begin
      lat = done ? 0 : -1;
    end
  endtask

  initial begin
    int lat, n;
    logic [63:0] fwd;
    logic [3:0] ro;
    logic [31:0] rx, ry;
    bit seen;
    vt[0]  = '{4'd8, 32'h12345678, 32'h0,        64'h12345678_00000000, -1};
    vt[1]  = '{4'd0, 32'hFFFFFFFF, 32'd2,        64'hFFFFFFFF_FFFFFFFE, 0};
    vt[2]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE, 0};
    vt[3]  = '{4'd1, 32'd3,        32'd4,        64'h00000000_0000000C, 0};
    vt[4]  = '{4'd7, 32'd1,        32'd13,       64'hFFFFFFFF_FFFFFFFF, 0};
    vt[5]  = '{4'd4, 32'd1,        32'd1,        64'h00000000_00000000, 0};
    vt[6]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34};
    vt[7]  = '{4'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 34};
    vt[8]  = '{4'd3, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 34};
    vt[9]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
    vt[10] = '{4'd9, 32'hDEADBEEF, 32'h0,        64'h00000000_DEADBEEF, -1};
    vt[11] = '{4'd2, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
    vt[12] = '{4'd2, 32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 34};
    vt[13] = '{4'd4, 32'hFFFFFFFF, 32'd3,        64'hFFFFFFFB_FFFFFFFC, 0};
    vt[14] = '{4'd6, 32'd2,        32'd3,        64'hFFFFFFFB_FFFFFFF6, 0};
    vt[15] = '{4'd12, 32'h5,       32'h6,        64'hFFFFFFFB_FFFFFFF6, -1};
    rst = 1'b1; op_valid = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", hilo_o, 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    rst = 1'b0;
    foreach (vt[i]) begin
      run(vt[i].op, vt[i].a, vt[i].b, lat, fwd);
      chk($sformatf("vec%0d_hilo", i), hilo_o, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(busy), 64'h0);
      if (vt[i].op inside {4'd8, 4'd9}) chk($sformatf("vec%0d_fwd", i), fwd, vt[i].exp);
    end
    mdl = vt[15].exp;
    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 9));
      rx = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       ry = 32'h0;
        1:       ry = $urandom_range(1, 9);
        2:       ry = 32'hFFFFFFFF;
        default: ry = $urandom;
      endcase
      run(ro, rx, ry, lat, fwd);
      mdl = ref_op(ro, rx, ry, mdl);
      chk($sformatf("rnd%0d_op%0d_hilo", i, ro), hilo_o, mdl);
      chk($sformatf("rnd%0d_op%0d_lat", i, ro), 64'(lat), 64'(exp_lat(ro)));
      if (ro inside {4'd8, 4'd9}) chk($sformatf("rnd%0d_fwd", i), fwd, mdl);
    end
    run(4'd8, 32'hAAAA5555, 32'h0, lat, fwd);
    run(4'd9, 32'h00001234, 32'h0, lat, fwd);
    mdl = 64'hAAAA5555_00001234;
    @(negedge clk);
    op_valid = 1'b1; op = 4'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    #1 op_valid = 1'b0;
    chk("cancel_busy_start", 64'(busy), 64'h1);
    repeat (11) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'h0);
    chk("cancel_done", 64'(done), 64'h0);
    chk("cancel_hilo", hilo_o, mdl);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("cancel_no_done", 64'(seen), 64'h0);
    chk("cancel_hilo_late", hilo_o, mdl);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd8; a = 32'hFFFF0000; cancel = 1'b1;
    #1 chk("idle_cancel_nofwd", hilo_o, mdl);
    @(posedge clk);
    #1 op_valid = 1'b0; cancel = 1'b0;
    chk("idle_cancel_hilo", hilo_o, mdl);
    chk("idle_cancel_busy", 64'(busy), 64'h0);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 op_valid = 1'b0;
    n = 4;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drop_lat", 64'(n), 64'(W + 2));
    chk("drop_hilo", hilo_o, 64'h00000002_0000000E);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("drop_no_second_done", 64'(seen), 64'h0);
    chk("drop_hilo_held", hilo_o, 64'h00000002_0000000E);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 chk("b2b_mult_done", 64'(done), 64'h1);
    chk("b2b_mult_hilo", hilo_o, 64'hC);
    @(negedge clk);
    op = 4'd4; a = 32'd2; b = 32'd5;
    #1 chk("b2b_done_at_issue", 64'(done), 64'h1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    chk("b2b_madd_hilo", hilo_o, 64'h16);
    chk("b2b_madd_done", 64'(done), 64'h1);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd2; a = 32'd12345; b = 32'd17;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_hilo", hilo_o, 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= done;
    end
    chk("rst_no_done", 64'(seen), 64'h0);
    chk("rst_hilo_late", hilo_o, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
